reset_sequencer: RTL

- Controller for the board reset resource. Arbitrates reset requests from several sources: wishbone soft reset, TTC resync and link loss.
- Defers soft requests long enough for the wishbone response to leave the chip.
- Asserts per-subsystem resets, then releases them in a fixed staged order once clocks and links are ready.
- Sits between the slow-control/TTC logic and the core subsystems: GBT, trigger, S-bits, VFAT control.

---
 rtl/reset_seq_pkg.sv | 29 ++
 rtl/reset_seq_timer.sv | 42 ++++
 rtl/reset_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and defaults for the board reset sequencer.
package reset_seq_pkg;

  // Sequencer states: the four active states plus IDLE.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DELAY      = 3'd1,
    ASSERT     = 3'd2,
    WAIT_READY = 3'd3,
    RELEASE    = 3'd4
  } state_e;

  // Width of the completed-sequence counter.
  localparam int unsigned COUNT_W = 16;

  // Default sizing and timing for the board build.
  localparam int unsigned DEF_NREQ      = 3;
  localparam int unsigned DEF_NSTAGES   = 4;
  localparam int unsigned DEF_DELAY_CNT = 1023;
  localparam int unsigned DEF_HOLD_CNT  = 31;
  localparam int unsigned DEF_GAP_CNT   = 255;
  localparam int unsigned DEF_CNT_BITS  = 10;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == '1) ? v : v + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// Loadable down-counter shared by the DELAY, ASSERT and RELEASE phases.
// Counts down to zero and parks there until reloaded.
module reset_seq_timer #(
  parameter int unsigned CNT_BITS  = 10,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic                clock_i,
  input  logic                reset_n_i,
  input  logic                load_i,
  input  logic [CNT_BITS-1:0] load_val_i,
  output logic                zero_o
);

  logic [CNT_BITS-1:0] cnt_q;
  logic [CNT_BITS-1:0] cnt_d;

  // Next count: load wins, otherwise decrement toward zero and hold.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves it
    // unassigned; a missing default infers a latch.
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_BITS'(1);
    end
  end

  // Counter register; comes out of reset preloaded with the power-up hold time.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    if (!reset_n_i) begin
      cnt_q <= CNT_BITS'(RESET_VAL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Board reset controller: collects reset requests, defers soft requests so the
// wishbone ack can leave the chip, asserts all subsystem resets, then releases
// them one stage at a time (stage 0 first) once clocks and links are ready.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned NREQ      = DEF_NREQ,
  parameter int unsigned NSTAGES   = DEF_NSTAGES,
  parameter int unsigned DELAY_CNT = DEF_DELAY_CNT,
  parameter int unsigned HOLD_CNT  = DEF_HOLD_CNT,
  parameter int unsigned GAP_CNT   = DEF_GAP_CNT,
  parameter int unsigned CNT_BITS  = DEF_CNT_BITS
) (
  input  logic               clock_i,
  input  logic               reset_n_i,
  input  logic               ready_i,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ-1:0]    mask_i,
  output logic [NSTAGES-1:0] stage_reset_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [NREQ-1:0]    cause_o,
  output logic [COUNT_W-1:0] reset_count_o
);

  // Stage index width; a single-stage build still needs a 1-bit index.
  localparam int unsigned KW = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;

  localparam logic [CNT_BITS-1:0] DELAY_V = CNT_BITS'(DELAY_CNT);
  localparam logic [CNT_BITS-1:0] HOLD_V  = CNT_BITS'(HOLD_CNT);
  localparam logic [CNT_BITS-1:0] GAP_V   = CNT_BITS'(GAP_CNT);
  localparam logic [KW-1:0]       LAST_K  = KW'(NSTAGES - 1);

  state_e               state_q, state_d;
  logic [NSTAGES-1:0]   stage_q, stage_d;
  logic [KW-1:0]        k_q, k_d;
  logic [NREQ-1:0]      cause_q, cause_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  logic                 tmr_load;
  logic [CNT_BITS-1:0]  tmr_val;
  logic                 tmr_zero;
  logic                 enter_assert;
  logic [NREQ-1:0]      hit;

  // Requests are level-sampled; every enabled requester counts, no priority.
  assign hit = req_i & mask_i;

  reset_seq_timer #(
    .CNT_BITS  (CNT_BITS),
    .RESET_VAL (HOLD_CNT)
  ) u_timer (
    .clock_i    (clock_i),
    .reset_n_i  (reset_n_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_d      = state_q;
    stage_d      = stage_q;
    k_d          = k_q;
    cause_d      = cause_q;
    count_d      = count_q;
    done_d       = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = HOLD_V;
    enter_assert = 1'b0;

    case (state_q)
      IDLE: begin
        stage_d = '0;
        if (!ready_i) begin
          // Losing clocks/links outranks any pending request.
          enter_assert = 1'b1;
          cause_d      = '0;
        end else if (hit != '0) begin
          state_d  = DELAY;
          tmr_load = 1'b1;
          tmr_val  = DELAY_V;
          cause_d  = hit;
        end
      end

      DELAY: begin
        // Outputs stay quiet while the wishbone response drains.
        if (!ready_i || tmr_zero) begin
          enter_assert = 1'b1;
        end
      end

      ASSERT: begin
        // Minimum hold is unconditional; ready is only consulted afterwards.
        stage_d = '1;
        if (tmr_zero) begin
          state_d = WAIT_READY;
        end
      end

      WAIT_READY: begin
        if (ready_i) begin
          if (NSTAGES == 1) begin
            stage_d = '0;
            state_d = IDLE;
            done_d  = 1'b1;
            count_d = sat_inc(count_q);
          end else begin
            stage_d[0] = 1'b0;
            k_d        = KW'(1);
            state_d    = RELEASE;
            tmr_load   = 1'b1;
            tmr_val    = GAP_V;
          end
        end
      end

      RELEASE: begin
        if (!ready_i) begin
          enter_assert = 1'b1;
        end else if (tmr_zero) begin
          stage_d[k_q] = 1'b0;
          if (k_q == LAST_K) begin
            state_d = IDLE;
            k_d     = '0;
            done_d  = 1'b1;
            count_d = sat_inc(count_q);
          end else begin
            k_d      = k_q + KW'(1);
            tmr_load = 1'b1;
            tmr_val  = GAP_V;
          end
        end
      end

      default: begin
        enter_assert = 1'b1;
      end
    endcase

    // Every entry into ASSERT re-arms all stages together and restarts the hold.
    if (enter_assert) begin
      state_d  = ASSERT;
      stage_d  = '1;
      k_d      = '0;
      tmr_load = 1'b1;
      tmr_val  = HOLD_V;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset lands in ASSERT so power-up sequences itself.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ASSERT;
      stage_q <= '1;
      k_q     <= '0;
      cause_q <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      k_q     <= k_d;
      cause_q <= cause_d;
      count_q <= count_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign stage_reset_o = stage_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign cause_o       = cause_q;
  assign reset_count_o = count_q;

endmodule
